// File: rtl/mul.sv
// Sequential radix-2 shift-add multiplier producing the full 2*WIDTH-bit product
// of two operands, each independently signed or unsigned.
module mul #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_start,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    input  logic             i_a_signed,
    input  logic             i_b_signed,
    output logic             o_busy,
    output logic             o_done,
    output logic             o_valid,
    output logic [WIDTH-1:0] o_lo,
    output logic [WIDTH-1:0] o_hi
);

    localparam int unsigned CNT_W = $clog2(WIDTH + 1);
    localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(WIDTH - 1);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_FIN  = 2'd2;

    logic [1:0]         state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0]   mcand_q, mcand_d;
    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic               neg_q, neg_d;
    logic               done_q, done_d;
    logic               valid_q, valid_d;
    logic [WIDTH-1:0]   lo_q, lo_d;
    logic [WIDTH-1:0]   hi_q, hi_d;

    logic               a_neg, b_neg;
    logic [WIDTH-1:0]   a_mag, b_mag;
    logic [WIDTH:0]     step_sum;
    logic [2*WIDTH-1:0] acc_step;
    logic [2*WIDTH-1:0] prod;

    // Most negative value negates to itself, which read unsigned is the exact magnitude.
    assign a_neg = i_a_signed & i_a[WIDTH-1];
    assign b_neg = i_b_signed & i_b[WIDTH-1];
    assign a_mag = a_neg ? -i_a : i_a;
    assign b_mag = b_neg ? -i_b : i_b;

    // Upper half accumulates partial products; lower half holds the remaining multiplier bits.
    assign step_sum = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, mcand_q};
    assign acc_step = acc_q[0] ? {step_sum, acc_q[WIDTH-1:1]} : {1'b0, acc_q[2*WIDTH-1:1]};
    assign prod     = neg_q ? -acc_q : acc_q;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        mcand_d = mcand_q;
        acc_d   = acc_q;
        neg_d   = neg_q;
        done_d  = 1'b0;
        valid_d = valid_q;
        lo_d    = lo_q;
        hi_d    = hi_q;
        if (i_start) begin
            mcand_d = a_mag;
            acc_d   = {{WIDTH{1'b0}}, b_mag};
            neg_d   = a_neg ^ b_neg;
            cnt_d   = '0;
            valid_d = 1'b0;
            state_d = ST_RUN;
        end else begin
            case (state_q)
                ST_RUN: begin
                    acc_d = acc_step;
                    cnt_d = cnt_q + CNT_ONE;
                    if (cnt_q == LAST_ITER) begin
                        state_d = ST_FIN;
                    end
                end
                ST_FIN: begin
                    {hi_d, lo_d} = prod;
                    done_d       = 1'b1;
                    valid_d      = 1'b1;
                    state_d      = ST_IDLE;
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            done_q  <= 1'b0;
            valid_q <= 1'b0;
            lo_q    <= '0;
            hi_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            done_q  <= done_d;
            valid_q <= valid_d;
            lo_q    <= lo_d;
            hi_q    <= hi_d;
        end
    end

    // Datapath registers carry no reset; they are only observed through the FSM.
    always_ff @(posedge i_clk) begin
        mcand_q <= mcand_d;
        acc_q   <= acc_d;
        neg_q   <= neg_d;
    end

    assign o_busy  = (state_q != ST_IDLE);
    assign o_done  = done_q;
    assign o_valid = valid_q;
    assign o_lo    = lo_q;
    assign o_hi    = hi_q;

endmodule

// File: tb/tb_mul.sv
// Self-checking bench for mul: directed corner cases, randomized operands against an
// arithmetic reference, abort-by-restart and mid-operation reset.
module tb_mul;

    localparam int unsigned WIDTH = 32;

    logic             clk = 1'b0;
    logic             rst;
    logic             start;
    logic [WIDTH-1:0] a, b;
    logic             a_signed, b_signed;
    logic             busy, done, valid;
    logic [WIDTH-1:0] lo, hi;

    int n_checks = 0;
    int n_fail   = 0;

    mul #(.WIDTH(WIDTH)) dut (
        .i_clk      (clk),
        .i_rst      (rst),
        .i_start    (start),
        .i_a        (a),
        .i_b        (b),
        .i_a_signed (a_signed),
        .i_b_signed (b_signed),
        .o_busy     (busy),
        .o_done     (done),
        .o_valid    (valid),
        .o_lo       (lo),
        .o_hi       (hi)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Reference: sign- or zero-extend each operand to 2*WIDTH bits and multiply.
    function automatic logic [63:0] model(input logic [31:0] x, input logic [31:0] y,
                                          input logic xs, input logic ys);
        logic [63:0] ex, ey;
        ex = xs ? {{32{x[31]}}, x} : {32'h0, x};
        ey = ys ? {{32{y[31]}}, y} : {32'h0, y};
        return ex * ey;
    endfunction

    task automatic scramble_inputs();
        a        = $urandom;
        b        = $urandom;
        a_signed = 1'($urandom_range(0, 1));
        b_signed = 1'($urandom_range(0, 1));
    endtask

    task automatic issue(input logic [31:0] x, input logic [31:0] y,
                         input logic xs, input logic ys);
        @(negedge clk);
        start    = 1'b1;
        a        = x;
        b        = y;
        a_signed = xs;
        b_signed = ys;
        @(posedge clk);
        #1;
        start = 1'b0;
        scramble_inputs();
    endtask

    task automatic run_op(input string tag, input logic [31:0] x, input logic [31:0] y,
                          input logic xs, input logic ys);
        logic [63:0] exp;
        int          lat;
        int          bad;
        exp = model(x, y, xs, ys);
        issue(x, y, xs, ys);
        check({tag, "_start_busy"}, 64'(busy), 64'd1);
        check({tag, "_start_valid"}, 64'(valid), 64'd0);
        lat = 0;
        bad = 0;
        while (!done && lat < int'(WIDTH) + 5) begin
            @(posedge clk);
            #1;
            lat++;
            if (!done && (!busy || valid)) bad++;
        end
        check({tag, "_latency"}, 64'(lat), 64'(WIDTH + 1));
        check({tag, "_busy_during_run"}, 64'(bad), 64'd0);
        check({tag, "_busy_at_done"}, 64'(busy), 64'd0);
        check({tag, "_valid"}, 64'(valid), 64'd1);
        check({tag, "_product"}, {hi, lo}, exp);
        @(posedge clk);
        #1;
        check({tag, "_done_one_cycle"}, 64'(done), 64'd0);
    endtask

    initial begin
        int pulses;
        rst      = 1'b1;
        start    = 1'b0;
        a        = '0;
        b        = '0;
        a_signed = 1'b0;
        b_signed = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_outputs", {59'(0), busy, done, valid, 2'b00}, 64'd0);
        check("reset_result", {hi, lo}, 64'd0);
        @(negedge clk);
        rst = 1'b0;

        run_op("u7x6", 32'd7, 32'd6, 1'b0, 1'b0);
        check("u7x6_exact", {hi, lo}, 64'h0000_0000_0000_002A);
        run_op("uFFxFF", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b0);
        check("uFFxFF_exact", {hi, lo}, 64'hFFFF_FFFE_0000_0001);
        run_op("sFFxFF", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 1'b1);
        check("sFFxFF_exact", {hi, lo}, 64'h0000_0000_0000_0001);
        run_op("suFE", 32'hFFFF_FFFE, 32'hFFFF_FFFF, 1'b1, 1'b0);
        check("suFE_exact", {hi, lo}, 64'hFFFF_FFFE_0000_0002);
        run_op("sMin", 32'h8000_0000, 32'h8000_0000, 1'b1, 1'b1);
        check("sMin_exact", {hi, lo}, 64'h4000_0000_0000_0000);
        run_op("usMin", 32'hFFFF_FFFF, 32'h8000_0000, 1'b0, 1'b1);

        // Results and valid hold across idle cycles with changing inputs.
        repeat (5) begin
            @(negedge clk);
            scramble_inputs();
        end
        #1;
        check("hold_result", {hi, lo}, model(32'hFFFF_FFFF, 32'h8000_0000, 1'b0, 1'b1));
        check("hold_valid", 64'(valid), 64'd1);

        for (int i = 0; i < 20; i++) begin
            run_op($sformatf("rnd%0d", i), $urandom, $urandom,
                   1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end

        // Restart ten cycles into an operation: only the second one completes.
        issue(32'd3, 32'd5, 1'b0, 1'b0);
        pulses = 0;
        repeat (9) begin
            @(posedge clk);
            #1;
            if (done) pulses++;
        end
        check("abort_no_done", 64'(pulses), 64'd0);
        run_op("restart9x9", 32'd9, 32'd9, 1'b0, 1'b0);
        check("restart_lo", 64'(lo), 64'h51);
        pulses = 0;
        repeat (40) begin
            @(posedge clk);
            #1;
            if (done) pulses++;
        end
        check("restart_single_done", 64'(pulses), 64'd0);

        // Reset five cycles into an operation.
        issue(32'h1234_5678, 32'h9ABC_DEF0, 1'b1, 1'b0);
        repeat (4) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("rst_mid_flags", {61'(0), busy, valid, done}, 64'd0);
        check("rst_mid_result", {hi, lo}, 64'd0);
        @(negedge clk);
        rst = 1'b0;
        pulses = 0;
        repeat (40) begin
            @(posedge clk);
            #1;
            if (done || busy) pulses++;
        end
        check("rst_no_done", 64'(pulses), 64'd0);

        run_op("post_rst", 32'hDEAD_BEEF, 32'h0000_0010, 1'b1, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
